// File: rtl/note_seq_pkg.sv
// Shared types and instruction-field layout for the score playback controller.
package note_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StDivide,
        StPlay,
        StHalt
    } state_e;

    localparam logic [2:0] OP_BPM  = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_HALT = 3'd2;

    localparam int unsigned TYPE_BIT = 15;
    localparam int unsigned OP_MSB   = 14;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned TGT_MSB  = 11;
    localparam int unsigned DUR_MSB  = 10;
    localparam int unsigned DUR_LSB  = 7;
    localparam int unsigned BPM_MSB  = 8;
    localparam int unsigned OCT_MSB  = 6;
    localparam int unsigned OCT_LSB  = 4;
    localparam int unsigned NOTE_MSB = 3;

    localparam logic [3:0] REST_NOTE = 4'hF;

endpackage

// File: rtl/serial_div.sv
// 32-bit restoring divider, one quotient bit per cycle; done pulses when quotient is final.
module serial_div (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] rem;
    logic [5:0]  cnt;
    logic [32:0] shifted;
    logic [32:0] diff;

    // The quotient register doubles as the dividend shifter.
    always_comb begin
        shifted = {rem, quotient[31]};
        diff    = shifted - {1'b0, divisor};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                cnt      <= 6'd32;
            end else if (cnt != 6'd0) begin
                if (!diff[32]) begin
                    rem      <= diff[31:0];
                    quotient <= {quotient[30:0], 1'b1};
                end else begin
                    rem      <= shifted[31:0];
                    quotient <= {quotient[30:0], 1'b0};
                end
                cnt <= cnt - 6'd1;
                if (cnt == 6'd1) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Score playback controller: fetches 16-bit instructions from SRAM, runs settings and
// times notes in sixteenth-note ticks for the tone generator.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned SRAM_WAIT   = 2,
    parameter int unsigned DEFAULT_BPM = 96
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rd,
    input  logic [15:0]       sram_data,
    output logic              note_start,
    output logic              note_valid,
    output logic [3:0]        note,
    output logic [2:0]        octave,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [8:0]        bpm
);

    // One sixteenth note is a quarter of a beat: CLK_HZ*60/(4*bpm) cycles.
    localparam logic [31:0] DIVIDEND   = 32'(CLK_HZ * 15);
    localparam logic [31:0] TICK_RESET = DIVIDEND / 32'(DEFAULT_BPM);
    localparam logic [7:0]  WAIT_LAST  = 8'(SRAM_WAIT);

    state_e      state;
    logic [15:0] ins;
    logic [31:0] tick_len;
    logic [35:0] remaining;
    logic [7:0]  wcnt;

    logic        is_note;
    logic [2:0]  op;
    logic [8:0]  ins_bpm;
    logic [3:0]  dur;
    logic        div_start;
    logic        div_done;
    logic [31:0] quotient;

    always_comb begin
        is_note   = ins[TYPE_BIT];
        op        = ins[OP_MSB:OP_LSB];
        ins_bpm   = ins[BPM_MSB:0];
        dur       = ins[DUR_MSB:DUR_LSB];
        div_start = (state == StDecode) && !is_note && (op == OP_BPM) && (ins_bpm != 9'd0);
    end

    serial_div u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  ({23'd0, ins_bpm}),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            sram_addr  <= '0;
            sram_rd    <= 1'b0;
            note_start <= 1'b0;
            note_valid <= 1'b0;
            note       <= '0;
            octave     <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            pc         <= '0;
            bpm        <= 9'(DEFAULT_BPM);
            tick_len   <= TICK_RESET;
            ins        <= '0;
            remaining  <= '0;
            wcnt       <= '0;
        end else begin
            note_start <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= StFetch;
                    end
                end
                StFetch: begin
                    if (wcnt == 8'd0) begin
                        sram_addr <= pc;
                        sram_rd   <= 1'b1;
                        wcnt      <= 8'd1;
                    end else if (wcnt == WAIT_LAST) begin
                        ins     <= sram_data;
                        pc      <= pc + 1'b1;
                        sram_rd <= 1'b0;
                        wcnt    <= 8'd0;
                        state   <= StDecode;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                StDecode: begin
                    if (is_note) begin
                        note       <= ins[NOTE_MSB:0];
                        octave     <= ins[OCT_MSB:OCT_LSB];
                        remaining  <= 36'({1'b0, dur} + 5'd1) * 36'(tick_len);
                        note_start <= 1'b1;
                        note_valid <= (ins[NOTE_MSB:0] != REST_NOTE);
                        state      <= StPlay;
                    end else begin
                        case (op)
                            OP_BPM: begin
                                if (ins_bpm != 9'd0) begin
                                    bpm   <= ins_bpm;
                                    state <= StDivide;
                                end else begin
                                    state <= StFetch;
                                end
                            end
                            OP_JUMP: begin
                                pc    <= ADDR_W'(ins[TGT_MSB:0]);
                                state <= StFetch;
                            end
                            OP_HALT: begin
                                busy   <= 1'b0;
                                halted <= 1'b1;
                                state  <= StHalt;
                            end
                            default: state <= StFetch;
                        endcase
                    end
                end
                StDivide: begin
                    if (div_done) begin
                        tick_len <= quotient;
                        state    <= StFetch;
                    end
                end
                StPlay: begin
                    // <= 1 also guards a zero-length note from wrapping.
                    if (remaining <= 36'd1) begin
                        note_valid <= 1'b0;
                        state      <= StFetch;
                    end else begin
                        remaining <= remaining - 36'd1;
                    end
                end
                StHalt: begin
                    note_valid <= 1'b0;
                    if (start) begin
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                        state  <= StFetch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 2-cycle SRAM model, CLK_HZ=1600 (250-cycle tick).
module tb_note_sequencer;

    localparam int unsigned ADDR_W = 18;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_rd;
    logic [15:0]       sram_data;
    logic              note_start;
    logic              note_valid;
    logic [3:0]        note;
    logic [2:0]        octave;
    logic              busy;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [8:0]        bpm;

    logic [15:0] mem [0:255];
    logic [15:0] sram_q;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Word at the driven address is valid two edges after the address edge.
    always @(posedge CLK) sram_q <= mem[sram_addr[7:0]];
    assign sram_data = sram_q;

    note_sequencer #(
        .CLK_HZ      (1600),
        .ADDR_W      (ADDR_W),
        .SRAM_WAIT   (2),
        .DEFAULT_BPM (96)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .sram_addr  (sram_addr),
        .sram_rd    (sram_rd),
        .sram_data  (sram_data),
        .note_start (note_start),
        .note_valid (note_valid),
        .note       (note),
        .octave     (octave),
        .busy       (busy),
        .halted     (halted),
        .pc         (pc),
        .bpm        (bpm)
    );

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    // Start is high across exactly one edge; returns in cycle 1 of the run.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(3);
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL rst_sram_addr got %0h exp 0", sram_addr); end
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL rst_sram_rd got %0h exp 0", sram_rd); end
        checks++; if (note_start !== 1'b0) begin errors++; $display("FAIL rst_note_start got %0h exp 0", note_start); end
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_note_valid got %0h exp 0", note_valid); end
        checks++; if (note !== 4'd0 || octave !== 3'd0) begin errors++; $display("FAIL rst_note_oct got %0h/%0h exp 0/0", note, octave); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_busy_halted got %0h/%0h exp 0/0", busy, halted); end
        checks++; if (pc !== 18'd0) begin errors++; $display("FAIL rst_pc got %0h exp 0", pc); end
        checks++; if (bpm !== 9'd96) begin errors++; $display("FAIL rst_bpm got %0d exp 96", bpm); end
        RST = 1'b0;
        step(2);
        checks++; if (busy !== 1'b0 || sram_rd !== 1'b0) begin errors++; $display("FAIL idle_hold got busy %0h rd %0h exp 0 0", busy, sram_rd); end
    endtask

    task automatic test_single_note();
        load(16'h8005, 16'h2000, 16'h2000);
        pulse_start();
        step(3);
        checks++; if (note_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL s1_c4 got ns %0h busy %0h exp 0 1", note_start, busy); end
        step(1);
        checks++; if (note_start !== 1'b1 || note_valid !== 1'b1) begin errors++; $display("FAIL s1_c5_start got ns %0h nv %0h exp 1 1", note_start, note_valid); end
        checks++; if (note !== 4'd5 || octave !== 3'd0) begin errors++; $display("FAIL s1_note got %0h/%0h exp 5/0", note, octave); end
        step(249);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s1_c254_valid got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s1_c255_valid got %0h exp 0", note_valid); end
        step(3);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL s1_c258_halted got %0h exp 0", halted); end
        step(1);
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL s1_halt got h %0h busy %0h exp 1 0", halted, busy); end
        checks++; if (pc !== 18'd2) begin errors++; $display("FAIL s1_pc got %0h exp 2", pc); end
    endtask

    task automatic test_back_to_back();
        // note 2 oct 3 dur 3, rest dur 0, halt
        load(16'h81B2, 16'h800F, 16'h2000);
        pulse_start();
        step(4);
        checks++; if (note_start !== 1'b1 || note !== 4'd2 || octave !== 3'd3) begin errors++; $display("FAIL s2_first got ns %0h n %0h o %0h exp 1 2 3", note_start, note, octave); end
        step(999);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s2_c1004_valid got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s2_c1005_valid got %0h exp 0", note_valid); end
        step(3);
        checks++; if (note_start !== 1'b0) begin errors++; $display("FAIL s2_c1008_early got %0h exp 0", note_start); end
        step(1);
        checks++; if (note_start !== 1'b1 || note_valid !== 1'b0 || note !== 4'hF) begin errors++; $display("FAIL s2_rest got ns %0h nv %0h n %0h exp 1 0 f", note_start, note_valid, note); end
        step(125);
        checks++; if (note_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL s2_mid_rest got nv %0h busy %0h exp 0 1", note_valid, busy); end
        step(128);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL s2_c1262_halted got %0h exp 0", halted); end
        step(1);
        checks++; if (halted !== 1'b1 || pc !== 18'd3) begin errors++; $display("FAIL s2_halt got h %0h pc %0h exp 1 3", halted, pc); end
    endtask

    task automatic test_tempo();
        load(16'h0078, 16'h8000, 16'h2000);
        pulse_start();
        step(4);
        checks++; if (bpm !== 9'd120 || busy !== 1'b1) begin errors++; $display("FAIL s3_bpm got %0d busy %0h exp 120 1", bpm, busy); end
        checks++; if (sram_rd !== 1'b0) begin errors++; $display("FAIL s3_div_no_fetch got %0h exp 0", sram_rd); end
        step(36);
        checks++; if (note_start !== 1'b0) begin errors++; $display("FAIL s3_c41_early got %0h exp 0", note_start); end
        step(1);
        checks++; if (note_start !== 1'b1) begin errors++; $display("FAIL s3_c42_start got %0h exp 1", note_start); end
        step(199);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s3_c241_valid got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s3_c242_valid got %0h exp 0", note_valid); end
        // SET_BPM 0 from a fresh reset is skipped without a divide.
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        load(16'h0000, 16'h8000, 16'h2000);
        pulse_start();
        step(8);
        checks++; if (note_start !== 1'b1 || bpm !== 9'd96) begin errors++; $display("FAIL s3_bpm0 got ns %0h bpm %0d exp 1 96", note_start, bpm); end
        step(249);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s3_bpm0_len got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s3_bpm0_end got %0h exp 0", note_valid); end
    endtask

    task automatic test_jump();
        logic [ADDR_W-1:0] addrs [0:3];
        int na;
        logic prev;
        na = 0;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) addrs[i] = '1;
        step(10);
        load(16'h3000, 16'h1010, 16'h8005);
        pulse_start();
        for (int i = 0; i < 100 && halted !== 1'b1; i++) begin
            if (sram_rd === 1'b1 && prev !== 1'b1) begin
                if (na < 4) addrs[na] = sram_addr;
                na++;
            end
            prev = sram_rd;
            step(1);
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL s4_timeout got halted %0h exp 1", halted); end
        checks++; if (na != 3) begin errors++; $display("FAIL s4_fetch_count got %0d exp 3", na); end
        checks++; if (addrs[0] !== 18'h0 || addrs[1] !== 18'h1 || addrs[2] !== 18'h10) begin
            errors++; $display("FAIL s4_addr_seq got %0h %0h %0h exp 0 1 10", addrs[0], addrs[1], addrs[2]);
        end
        checks++; if (pc !== 18'h11) begin errors++; $display("FAIL s4_pc got %0h exp 11", pc); end
    endtask

    task automatic test_abort();
        load(16'h8005, 16'h2000, 16'h2000);
        pulse_start();
        step(99);
        pulse_start();
        checks++; if (pc !== 18'd1 || note_valid !== 1'b1) begin errors++; $display("FAIL s5_start_busy got pc %0h nv %0h exp 1 1", pc, note_valid); end
        step(153);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s5_c254_valid got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s5_c255_valid got %0h exp 0", note_valid); end
        step(4);
        checks++; if (halted !== 1'b1 || pc !== 18'd2) begin errors++; $display("FAIL s5_halt got h %0h pc %0h exp 1 2", halted, pc); end
        pulse_start();
        step(3);
        checks++; if (sram_addr !== 18'd0 || halted !== 1'b0) begin errors++; $display("FAIL s5_restart got addr %0h h %0h exp 0 0", sram_addr, halted); end
        step(1);
        checks++; if (note_start !== 1'b1) begin errors++; $display("FAIL s5_restart_note got %0h exp 1", note_start); end
        step(45);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        checks++; if (note_valid !== 1'b0 || note !== 4'd0 || octave !== 3'd0 || note_start !== 1'b0) begin
            errors++; $display("FAIL s5_play_rst_note got nv %0h n %0h o %0h ns %0h exp 0 0 0 0", note_valid, note, octave, note_start);
        end
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || pc !== 18'd0 || sram_addr !== 18'd0 || sram_rd !== 1'b0) begin
            errors++; $display("FAIL s5_play_rst_ctl got b %0h h %0h pc %0h a %0h rd %0h exp 0 0 0 0 0", busy, halted, pc, sram_addr, sram_rd);
        end
        step(2);
        checks++; if (busy !== 1'b0 || note_valid !== 1'b0) begin errors++; $display("FAIL s5_play_rst_idle got b %0h nv %0h exp 0 0", busy, note_valid); end
        load(16'h0078, 16'h2000, 16'h2000);
        pulse_start();
        step(9);
        checks++; if (bpm !== 9'd120) begin errors++; $display("FAIL s5_div_bpm got %0d exp 120", bpm); end
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        checks++; if (bpm !== 9'd96 || busy !== 1'b0 || pc !== 18'd0 || sram_addr !== 18'd0) begin
            errors++; $display("FAIL s5_div_rst got bpm %0d b %0h pc %0h a %0h exp 96 0 0 0", bpm, busy, pc, sram_addr);
        end
        step(40);
        checks++; if (busy !== 1'b0 || bpm !== 9'd96) begin errors++; $display("FAIL s5_div_rst_hold got b %0h bpm %0d exp 0 96", busy, bpm); end
        load(16'h8005, 16'h2000, 16'h2000);
        pulse_start();
        step(253);
        checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL s5_tick_kept got %0h exp 1", note_valid); end
        step(1);
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL s5_tick_end got %0h exp 0", note_valid); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
        test_reset();
        test_single_note();
        test_back_to_back();
        test_tempo();
        test_jump();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Top-level playback controller for the SRAM-resident score. It fetches 16-bit instructions from SRAM, executes setting instructions (tempo, jump, halt), and times note instructions in sixteenth-note ticks. It drives note/octave to the tone generator (freqCalc plus the speaker counter), replacing the fixed per-beat fetch loop. It is the sole SRAM read master; the top level ties SRAM control pins to constant read mode.

Parameters:
CLK_HZ, 50000000, input clock frequency
ADDR_W, 18, SRAM word address width
SRAM_WAIT, 2, cycles from address drive to valid SRAM_D (≥1)
DEFAULT_BPM, 96, tempo after reset

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; begins playback from address 0 when idle or halted
sram_addr  out  ADDR_W  SRAM word address
sram_rd  out  1  high while a fetch is in flight (debug/arbitration hook)
sram_data  in  16  SRAM read data
note_start  out  1  1-cycle pulse when a note or rest begins
note_valid  out  1  high while a non-rest note sounds
note  out  4  note index to freqCalc
octave  out  3  octave to freqCalc
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
pc  out  ADDR_W  address of next instruction
bpm  out  9  current tempo

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- Reset values: sram_addr=0, sram_rd=0, note_start=0, note_valid=0, note=0, octave=0, busy=0, halted=0, pc=0, bpm=DEFAULT_BPM, tick_len=CLK_HZ*15/DEFAULT_BPM (constant), state=IDLE. RST in any state, including mid-divide or mid-note, aborts everything in the same cycle.
- Instruction format:
  - bit15=1 NOTE: [3:0] note (4'hF = rest), [6:4] octave, [10:7] dur; length is (dur+1) sixteenths.
  - bit15=0 SETTING: [14:12] op. 0 SET_BPM with [8:0] bpm. 1 JUMP with [11:0] target, zero-extended. 2 HALT. Other ops are a NOP.
- States and transitions:
  - IDLE: on start, pc←0, go to FETCH.
  - FETCH: cycle 0 drives sram_addr←pc and sram_rd=1. Data is sampled on the SRAM_WAIT-th following edge into ins, then pc←pc+1 (wraps 2^ADDR_W−1→0), sram_rd←0, go to DECODE.
  - DECODE (1 cycle):
    - NOTE: load the note/octave registers, load remaining←(dur+1)*tick_len, pulse note_start, set note_valid=(note≠F), go to PLAY.
    - SET_BPM with bpm≠0: bpm←value, start the divider, go to DIVIDE. With bpm=0: ignore it and return to FETCH.
    - JUMP: pc←target, go to FETCH.
    - HALT: go to HALT.
    - NOP: go to FETCH.
  - DIVIDE: wait for div_done, latch tick_len←quotient, go to FETCH. Takes 32 cycles plus 1 load cycle.
  - PLAY: decrement remaining each cycle; at remaining==1, clear note_valid and go to FETCH.
  - HALT: note_valid=0; start re-enters FETCH with pc←0.
- start is ignored while busy.
- Note-to-note spacing: note_start-to-note_start = (dur+1)*tick_len + SRAM_WAIT + 2 cycles.
- Widths: tick_len 32 bits; remaining 36 bits; the dividend CLK_HZ*15 is computed as a 32-bit constant. Any truncation of the quotient is accepted.

Decomposition:
- Package note_seq_pkg holds:
  - state enum;
  - opcode constants OP_BPM, OP_JUMP, OP_HALT;
  - field bit positions;
  - REST_NOTE=4'hF.
- Sub-module serial_div: 32-bit restoring divider, 1 bit per cycle, with ports start/dividend/divisor/quotient/done. It is shared style with any future tempo logic.

Test Plan:
- Test parameters: CLK_HZ=1600 (tick_len=250 at 96 bpm), SRAM_WAIT=2, with an SRAM model returning the word at the driven address after 2 cycles.
- Scenario 1: program 0x8005 (note 5, octave 0, dur 0), 0x2000 (HALT); pulse start → note_start in cycle 5, note_valid high 250 cycles, then halted=1, pc=2.
- Scenario 2: program NOTE dur=3, NOTE rest dur=0, HALT → second note_start exactly 1004 cycles after the first; note_valid stays low during the rest; spacing to HALT is correct.
- Scenario 3: SET_BPM 120 then NOTE dur=0 → DIVIDE lasts 33 cycles; the note lasts 200 cycles; bpm=120. SET_BPM 0 → bpm stays 96 and no DIVIDE state occurs.
- Scenario 4: JUMP 0x010 at address 1; word at 0x010 is HALT → sram_addr sequence 0,1,0x10; pc=0x11 at halt.
- Scenario 5: assert RST for 1 cycle during PLAY, then during DIVIDE → all outputs return to reset values the next cycle. A start pulse mid-PLAY has no effect; start in HALT restarts at address 0.
